// File: rtl/p2p_pkg.sv
// Shared types and default widths for the p2p RX packet gate.
package p2p_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    PASS   = 2'd2,
    DROP   = 2'd3
  } p2p_rx_gate_state_t;

  localparam int P2P_DATA_W = 512;
  localparam int P2P_CNT_W  = 32;

endpackage

// File: rtl/p2p_sat_cnt.sv
// Saturating event counter; a clear in the same cycle as an event loads 1.
module p2p_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CNT_ONE : CNT_ZERO;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/p2p_rx_pkt_gate.sv
// Packet-boundary RX gate: drops whole packets on request, counts pass/drop/error.
// Optional P2P_RX_GATE_RESYNC_EN: discard up to the first tlast after reset.
module p2p_rx_pkt_gate
  import p2p_pkg::*;
#(
  parameter  int DATA_W = P2P_DATA_W,
  parameter  int CNT_W  = P2P_CNT_W,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              cmac_clk,
  input  logic              mod_rst,
  input  logic              block_rx,
  input  logic              stats_clr,
  input  logic              s_axis_cmac_rx_tvalid,
  input  logic [DATA_W-1:0] s_axis_cmac_rx_tdata,
  input  logic [KEEP_W-1:0] s_axis_cmac_rx_tkeep,
  input  logic              s_axis_cmac_rx_tlast,
  input  logic              s_axis_cmac_rx_tuser_err,
  output logic              m_axis_adap_rx_tvalid,
  output logic [DATA_W-1:0] m_axis_adap_rx_tdata,
  output logic [KEEP_W-1:0] m_axis_adap_rx_tkeep,
  output logic              m_axis_adap_rx_tlast,
  output logic              m_axis_adap_rx_tuser_err,
  output logic [CNT_W-1:0]  pkt_pass_cnt,
  output logic [CNT_W-1:0]  pkt_drop_cnt,
  output logic [CNT_W-1:0]  pkt_err_cnt
);

`ifdef P2P_RX_GATE_RESYNC_EN
  localparam p2p_rx_gate_state_t RST_STATE = RESYNC;
`else
  localparam p2p_rx_gate_state_t RST_STATE = IDLE;
`endif

  p2p_rx_gate_state_t r_state;
  logic               w_fwd;
  logic               w_drop_inc;
  logic               w_pass_inc;
  logic               w_err_inc;

  // RESYNC discards without counting, so it falls into the default arm.
  always_comb begin
    w_fwd      = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      IDLE: begin
        w_fwd      = s_axis_cmac_rx_tvalid & ~block_rx;
        w_drop_inc = s_axis_cmac_rx_tvalid & block_rx & s_axis_cmac_rx_tlast;
      end
      PASS: begin
        w_fwd      = s_axis_cmac_rx_tvalid;
        w_drop_inc = 1'b0;
      end
      DROP: begin
        w_fwd      = 1'b0;
        w_drop_inc = s_axis_cmac_rx_tvalid & s_axis_cmac_rx_tlast;
      end
      default: begin
        w_fwd      = 1'b0;
        w_drop_inc = 1'b0;
      end
    endcase
  end

  assign w_pass_inc = w_fwd & s_axis_cmac_rx_tlast;
  assign w_err_inc  = w_pass_inc & s_axis_cmac_rx_tuser_err;

  always_ff @(posedge cmac_clk) begin
    if (mod_rst) begin
      r_state                  <= RST_STATE;
      m_axis_adap_rx_tvalid    <= 1'b0;
      m_axis_adap_rx_tdata     <= {DATA_W{1'b0}};
      m_axis_adap_rx_tkeep     <= {KEEP_W{1'b0}};
      m_axis_adap_rx_tlast     <= 1'b0;
      m_axis_adap_rx_tuser_err <= 1'b0;
    end else begin
      m_axis_adap_rx_tvalid    <= w_fwd;
      m_axis_adap_rx_tlast     <= w_fwd & s_axis_cmac_rx_tlast;
      m_axis_adap_rx_tuser_err <= w_fwd & s_axis_cmac_rx_tuser_err;
      if (w_fwd) begin
        m_axis_adap_rx_tdata <= s_axis_cmac_rx_tdata;
        m_axis_adap_rx_tkeep <= s_axis_cmac_rx_tkeep;
      end else begin
        m_axis_adap_rx_tdata <= m_axis_adap_rx_tdata;
        m_axis_adap_rx_tkeep <= m_axis_adap_rx_tkeep;
      end
      if (s_axis_cmac_rx_tvalid) begin
        case (r_state)
          RESYNC: r_state <= s_axis_cmac_rx_tlast ? IDLE : RESYNC;
          IDLE: begin
            if (s_axis_cmac_rx_tlast) begin
              r_state <= IDLE;
            end else begin
              r_state <= block_rx ? DROP : PASS;
            end
          end
          PASS:    r_state <= s_axis_cmac_rx_tlast ? IDLE : PASS;
          DROP:    r_state <= s_axis_cmac_rx_tlast ? IDLE : DROP;
          default: r_state <= RST_STATE;
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  p2p_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .i_clk (cmac_clk),
    .i_rst (mod_rst),
    .i_clr (stats_clr),
    .i_inc (w_pass_inc),
    .o_cnt (pkt_pass_cnt)
  );

  p2p_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .i_clk (cmac_clk),
    .i_rst (mod_rst),
    .i_clr (stats_clr),
    .i_inc (w_drop_inc),
    .o_cnt (pkt_drop_cnt)
  );

  p2p_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk (cmac_clk),
    .i_rst (mod_rst),
    .i_clr (stats_clr),
    .i_inc (w_err_inc),
    .o_cnt (pkt_err_cnt)
  );

endmodule

// File: tb/tb_p2p_rx_pkt_gate.sv
// Scoreboard bench for p2p_rx_pkt_gate (512-bit data, 4-bit counters to reach saturation).
module tb_p2p_rx_pkt_gate;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int CW = 4;

`ifdef P2P_RX_GATE_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  logic          cmac_clk;
  logic          mod_rst;
  logic          block_rx;
  logic          stats_clr;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_terr;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_terr;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] err_cnt;

  p2p_rx_pkt_gate #(.DATA_W(DW), .CNT_W(CW)) dut (
    .cmac_clk                 (cmac_clk),
    .mod_rst                  (mod_rst),
    .block_rx                 (block_rx),
    .stats_clr                (stats_clr),
    .s_axis_cmac_rx_tvalid    (s_tvalid),
    .s_axis_cmac_rx_tdata     (s_tdata),
    .s_axis_cmac_rx_tkeep     (s_tkeep),
    .s_axis_cmac_rx_tlast     (s_tlast),
    .s_axis_cmac_rx_tuser_err (s_terr),
    .m_axis_adap_rx_tvalid    (m_tvalid),
    .m_axis_adap_rx_tdata     (m_tdata),
    .m_axis_adap_rx_tkeep     (m_tkeep),
    .m_axis_adap_rx_tlast     (m_tlast),
    .m_axis_adap_rx_tuser_err (m_terr),
    .pkt_pass_cnt             (pass_cnt),
    .pkt_drop_cnt             (drop_cnt),
    .pkt_err_cnt              (err_cnt)
  );

  initial cmac_clk = 1'b0;
  always #5 cmac_clk = ~cmac_clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          e;
    logic [CW-1:0] pc;
    logic [CW-1:0] dc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: packet-level view of the link.
  bit            m_resync;
  bit            m_mid;
  bit            m_mid_fwd;
  logic [DW-1:0] m_dprev;
  logic [KW-1:0] m_kprev;
  logic [CW-1:0] m_pc, m_dc, m_ec;

  logic [KW-1:0] all_k;
  logic [DW-1:0] one_d;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 4'd1;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one cycle, predict its outcome, then compare one edge later.
  task automatic step(input bit rst, input bit clr, input bit blk, input bit v, input bit l,
                      input bit e, input logic [DW-1:0] d, input logic [KW-1:0] k);
    exp_t x;
    exp_t got;
    bit   fwd;
    bit   drop_ev;
    mod_rst   = rst;
    stats_clr = clr;
    block_rx  = blk;
    s_tvalid  = v;
    s_tlast   = l;
    s_terr    = e;
    s_tdata   = d;
    s_tkeep   = k;
    x = '0;
    if (rst) begin
      m_resync  = RESYNC_EN;
      m_mid     = 1'b0;
      m_mid_fwd = 1'b0;
      m_dprev   = '0;
      m_kprev   = '0;
      m_pc = '0; m_dc = '0; m_ec = '0;
    end else begin
      fwd = 1'b0;
      drop_ev = 1'b0;
      if (v) begin
        if (m_resync) begin
          if (l) m_resync = 1'b0;
        end else if (!m_mid) begin
          fwd       = !blk;
          m_mid_fwd = !blk;
          m_mid     = !l;
          drop_ev   = blk && l;
        end else begin
          fwd     = m_mid_fwd;
          drop_ev = !m_mid_fwd && l;
          if (l) m_mid = 1'b0;
        end
      end
      if (clr) begin
        m_pc = '0; m_dc = '0; m_ec = '0;
      end
      if (fwd && l) m_pc = sat_inc(m_pc);
      if (fwd && l && e) m_ec = sat_inc(m_ec);
      if (drop_ev) m_dc = sat_inc(m_dc);
      if (fwd) begin
        m_dprev = d;
        m_kprev = k;
      end
      x.v = fwd;
      x.l = fwd && l;
      x.e = fwd && e;
    end
    x.d = m_dprev;
    x.k = m_kprev;
    x.pc = m_pc; x.dc = m_dc; x.ec = m_ec;
    sb_q.push_back(x);
    @(posedge cmac_clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      got = sb_q.pop_front();
      check("tvalid", DW'(m_tvalid), DW'(got.v));
      check("tdata", m_tdata, got.d);
      check("tkeep", DW'(m_tkeep), DW'(got.k));
      check("tlast", DW'(m_tlast), DW'(got.l));
      check("tuser_err", DW'(m_terr), DW'(got.e));
      check("pass_cnt", DW'(pass_cnt), DW'(got.pc));
      check("drop_cnt", DW'(drop_cnt), DW'(got.dc));
      check("err_cnt", DW'(err_cnt), DW'(got.ec));
    end
  endtask

  task automatic beat(input bit blk, input bit l, input bit e);
    step(1'b0, 1'b0, blk, 1'b1, l, e, rnd_data(), all_k);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), all_k);
  endtask

  initial begin
    all_k = {KW{1'b1}};
    one_d = {{(DW-1){1'b0}}, 1'b1};
    m_resync = RESYNC_EN; m_mid = 0; m_mid_fwd = 0;
    m_dprev = '0; m_kprev = '0; m_pc = '0; m_dc = '0; m_ec = '0;

    // Reset with garbage beats on the input.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rnd_data(), all_k);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rnd_data(), all_k);
    idle_cycle();
    beat(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), all_k);

    // Single-beat packet with data 1.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, one_d, all_k);
    check("single_pass_cnt", DW'(pass_cnt), DW'(1));
    idle_cycle();

    // block raised mid-packet is ignored; then a blocked 2-beat packet.
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    idle_cycle();
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    idle_cycle();

    // block released mid-drop; next packet passes.
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);

    // Error flag on the tlast beat of a forwarded packet.
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    idle_cycle();

    // Reset on beat 2 of a 4-beat packet, then a fresh packet.
    beat(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rnd_data(), all_k);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    check("rst_tail_pass_cnt", DW'(pass_cnt), DW'(RESYNC_EN ? 0 : 1));
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);

    // Saturation and clear-then-count.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), all_k);
    for (int i = 0; i < 17; i++) beat(1'b0, 1'b1, 1'b0);
    check("pass_saturated", DW'(pass_cnt), DW'(15));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rnd_data(), all_k);
    check("clr_with_inc", DW'(pass_cnt), DW'(1));

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 150) == 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           rnd_data(), KW'({$urandom, $urandom}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
